// File: rtl/demod_readback_pkg.sv
// -----------------------------------------------------------------------------
// demod_readback_pkg
// Shared constants for the demod result readback block: PC-port address map,
// CTRL bit positions, FSM state codes, entry layout widths and read-select
// codes, plus a helper that packs the STATUS word.
// Optional feature macro: READBACK_TIMESTAMP_EN. When it is defined, each
// stored entry is widened by a 32-bit capture timestamp.
// -----------------------------------------------------------------------------
package demod_readback_pkg;

  // PC-port address map
  localparam logic [13:0] STATUS_ADDR      = 14'h0000;
  localparam logic [13:0] CTRL_ADDR        = 14'h0001;
  localparam logic [13:0] DEFAULT_BUF_BASE = 14'h1000;

  // CTRL register bit indices
  localparam int unsigned CTRL_CLEAR_BIT = 0;
  localparam int unsigned CTRL_ARM_BIT   = 1;

  // FSM state codes, also reported in STATUS[30:29]
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  // Entry layout: five 16-bit lanes, optionally followed by a timestamp
  localparam int unsigned LANE_W       = 16;
  localparam int unsigned ENTRY_W      = 80;
  localparam int unsigned TS_W         = 32;
`ifdef READBACK_TIMESTAMP_EN
  localparam int unsigned STORE_W      = ENTRY_W + TS_W;
`else
  localparam int unsigned STORE_W      = ENTRY_W;
`endif
  localparam int unsigned STATUS_CNT_W = 17;
  localparam int unsigned RD_W         = 33;

  // Registered read-source select
  localparam logic [1:0] SEL_NONE   = 2'd0;
  localparam logic [1:0] SEL_STATUS = 2'd1;
  localparam logic [1:0] SEL_ENTRY  = 2'd2;

  // STATUS: [31] overflow, [30:29] state, [16:0] count
  function automatic logic [31:0] status_word(input logic ovf,
                                              input logic [1:0] st,
                                              input logic [STATUS_CNT_W-1:0] cnt);
    return {ovf, st, 12'h000, cnt};
  endfunction

endpackage

// File: rtl/readback_buffer.sv
// -----------------------------------------------------------------------------
// readback_buffer
// Simple dual-port RAM holding captured result entries. One synchronous write
// port and one registered read port. Contents are not reset; the read register
// only updates when rd_en is high, so a read result holds until the next read.
// Ports:
//   clk      clock
//   wr_en    write strobe
//   wr_addr  write entry index
//   wr_data  write entry payload
//   rd_en    read strobe
//   rd_addr  read entry index
//   rd_data  registered read payload
// -----------------------------------------------------------------------------
module readback_buffer #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned W     = 80,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port, holds between reads
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/demod_result_readback.sv
// -----------------------------------------------------------------------------
// demod_result_readback
// Captures 5-lane x 16-bit result beats into an on-chip buffer under control
// of a small IDLE/CAPTURE/FULL state machine, and serves PC-port reads of the
// STATUS/CTRL window and of the buffer entries (4 words per entry).
// Optional feature macro: READBACK_TIMESTAMP_EN -- stores a free-running cycle
// count per entry and returns it as word 3 instead of the entry index.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   res_valid, res_data_0..4    result beat strobe and lanes
//   MEM_sdi_mem_S_address       PC-port word address
//   MEM_sdi_mem_S_rdEn/wrEn     read / write strobes
//   MEM_sdi_mem_S_wrData        write data (only CTRL is decoded)
//   MEM_sdi_mem_M_rdData        read data, bit 32 = address hit
//   buf_full                    high while in FULL
//   capture_active              high while in CAPTURE
// -----------------------------------------------------------------------------
module demod_result_readback
  import demod_readback_pkg::*;
#(
  parameter int unsigned DEPTH    = 256,
  parameter logic [13:0] BUF_BASE = DEFAULT_BUF_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  input  logic [15:0] res_data_0,
  input  logic [15:0] res_data_1,
  input  logic [15:0] res_data_2,
  input  logic [15:0] res_data_3,
  input  logic [15:0] res_data_4,
  input  logic [13:0] MEM_sdi_mem_S_address,
  input  logic        MEM_sdi_mem_S_rdEn,
  input  logic        MEM_sdi_mem_S_wrEn,
  input  logic [32:0] MEM_sdi_mem_S_wrData,
  output logic [32:0] MEM_sdi_mem_M_rdData,
  output logic        buf_full,
  output logic        capture_active
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CW       = $clog2(DEPTH + 1);
  localparam int unsigned BUF_SPAN = DEPTH * 4;

  logic [1:0]         state, state_nxt;
  logic [CW-1:0]      count, count_nxt;
  logic               overflow, overflow_nxt;
  logic               ctrl_wr, clear, arm;
  logic               capture_we;
  logic [STORE_W-1:0] wr_entry;

  // CTRL decode
  assign ctrl_wr = MEM_sdi_mem_S_wrEn && (MEM_sdi_mem_S_address == CTRL_ADDR);
  assign clear   = ctrl_wr && MEM_sdi_mem_S_wrData[CTRL_CLEAR_BIT];
  assign arm     = ctrl_wr && MEM_sdi_mem_S_wrData[CTRL_ARM_BIT];

  // Next-state logic; CLEAR overrides everything, and CLEAR+ARM lands in
  // CAPTURE with count=0 on the following cycle
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    overflow_nxt = overflow;
    capture_we   = 1'b0;
    if (clear) begin
      count_nxt    = '0;
      overflow_nxt = 1'b0;
      state_nxt    = arm ? ST_CAPTURE : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state_nxt = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (res_valid) begin
            capture_we = 1'b1;
            count_nxt  = count + CW'(1);
            if (count_nxt == CW'(DEPTH)) begin
              state_nxt = ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (res_valid) begin
            overflow_nxt = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, count and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      count          <= '0;
      overflow       <= 1'b0;
      buf_full       <= 1'b0;
      capture_active <= 1'b0;
    end else begin
      state          <= state_nxt;
      count          <= count_nxt;
      overflow       <= overflow_nxt;
      buf_full       <= (state_nxt == ST_FULL);
      capture_active <= (state_nxt == ST_CAPTURE);
    end
  end

`ifdef READBACK_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  // Free-running capture timestamp
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
    end
  end

  assign wr_entry = {ts_cnt, res_data_4, res_data_3, res_data_2, res_data_1, res_data_0};
`else
  assign wr_entry = {res_data_4, res_data_3, res_data_2, res_data_1, res_data_0};
`endif

  // Address decode; count is sampled pre-update so a same-cycle write misses
  logic [13:0]   buf_off;
  logic [AW-1:0] rd_n;
  logic [1:0]    rd_k;
  logic          in_buf, reg_hit, entry_hit;

  assign buf_off   = MEM_sdi_mem_S_address - BUF_BASE;
  assign rd_n      = buf_off[AW+1:2];
  assign rd_k      = buf_off[1:0];
  assign in_buf    = (MEM_sdi_mem_S_address >= BUF_BASE) &&
                     ({1'b0, MEM_sdi_mem_S_address} < ({1'b0, BUF_BASE} + 15'(BUF_SPAN)));
  assign reg_hit   = (MEM_sdi_mem_S_address == STATUS_ADDR) ||
                     (MEM_sdi_mem_S_address == CTRL_ADDR);
  assign entry_hit = in_buf && (CW'(rd_n) < count);

  logic [STORE_W-1:0] buf_q;

  readback_buffer #(
    .DEPTH (DEPTH),
    .W     (STORE_W),
    .AW    (AW)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (capture_we),
    .wr_addr (count[AW-1:0]),
    .wr_data (wr_entry),
    .rd_en   (MEM_sdi_mem_S_rdEn && entry_hit),
    .rd_addr (rd_n),
    .rd_data (buf_q)
  );

  // Read-side registers, updated only on rdEn so the result holds
  logic [1:0]    rd_sel;
  logic [1:0]    rd_word;
  logic [AW-1:0] rd_index;
  logic [31:0]   status_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sel   <= SEL_NONE;
      rd_word  <= 2'd0;
      rd_index <= '0;
      status_q <= 32'h0;
    end else if (MEM_sdi_mem_S_rdEn) begin
      rd_word  <= rd_k;
      rd_index <= rd_n;
      status_q <= status_word(overflow, state, STATUS_CNT_W'(count));
      if (reg_hit) begin
        rd_sel <= SEL_STATUS;
      end else if (entry_hit) begin
        rd_sel <= SEL_ENTRY;
      end else begin
        rd_sel <= SEL_NONE;
      end
    end
  end

  // Read data mux over registered sources
  logic [31:0] entry_word;

  always_comb begin
    entry_word           = 32'h0;
    MEM_sdi_mem_M_rdData = '0;
    case (rd_word)
      2'd0:    entry_word = buf_q[31:0];
      2'd1:    entry_word = buf_q[63:32];
      2'd2:    entry_word = {16'h0000, buf_q[79:64]};
`ifdef READBACK_TIMESTAMP_EN
      default: entry_word = buf_q[ENTRY_W+TS_W-1:ENTRY_W];
`else
      default: entry_word = 32'(rd_index);
`endif
    endcase
    case (rd_sel)
      SEL_STATUS: MEM_sdi_mem_M_rdData = {1'b1, status_q};
      SEL_ENTRY:  MEM_sdi_mem_M_rdData = {1'b1, entry_word};
      default:    MEM_sdi_mem_M_rdData = '0;
    endcase
  end

  // Bits intentionally not decoded
  logic unused_bits;
`ifdef READBACK_TIMESTAMP_EN
  assign unused_bits = ^{MEM_sdi_mem_S_wrData[32:2], buf_off[13:AW+2], rd_index};
`else
  assign unused_bits = ^{MEM_sdi_mem_S_wrData[32:2], buf_off[13:AW+2]};
`endif

endmodule

// File: tb/tb_demod_result_readback.sv
// -----------------------------------------------------------------------------
// tb_demod_result_readback
// Scoreboard bench: each read pushes the value computed by a behavioural model
// of the result buffer; a monitor pops and compares when read data is due.
// -----------------------------------------------------------------------------
module tb_demod_result_readback;

  localparam int unsigned DEPTH    = 4;
  localparam logic [13:0] BUF_BASE = 14'h1000;

  logic        clk;
  logic        rst;
  logic        res_valid;
  logic [15:0] res_data_0, res_data_1, res_data_2, res_data_3, res_data_4;
  logic [13:0] address;
  logic        rd_en;
  logic        wr_en;
  logic [32:0] wr_data;
  logic [32:0] rd_data;
  logic        buf_full;
  logic        capture_active;

  demod_result_readback #(
    .DEPTH    (DEPTH),
    .BUF_BASE (BUF_BASE)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .res_valid             (res_valid),
    .res_data_0            (res_data_0),
    .res_data_1            (res_data_1),
    .res_data_2            (res_data_2),
    .res_data_3            (res_data_3),
    .res_data_4            (res_data_4),
    .MEM_sdi_mem_S_address (address),
    .MEM_sdi_mem_S_rdEn    (rd_en),
    .MEM_sdi_mem_S_wrEn    (wr_en),
    .MEM_sdi_mem_S_wrData  (wr_data),
    .MEM_sdi_mem_M_rdData  (rd_data),
    .buf_full              (buf_full),
    .capture_active        (capture_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: state 0=IDLE 1=CAPTURE 2=FULL
  int          mstate;
  int          mcount;
  bit          movf;
  logic [15:0] m_lane [DEPTH][5];
  logic [31:0] m_ts   [DEPTH];
  logic [31:0] tb_cyc;

  logic [32:0] exp_q [$];
  logic [32:0] last_exp;
  int          checks;
  int          errors;

  always @(posedge clk) begin
    if (rst) tb_cyc <= 32'd0;
    else     tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic check33(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] exp_read(input logic [13:0] a);
    int off;
    int n;
    int k;
    if (a == 14'h0000 || a == 14'h0001)
      return {1'b1, movf, 2'(mstate), 12'h000, 17'(mcount)};
    off = int'(a) - int'(BUF_BASE);
    if (off < 0 || off >= int'(4 * DEPTH)) return 33'h0;
    n = off / 4;
    k = off % 4;
    if (n >= mcount) return 33'h0;
    case (k)
      0:       return {1'b1, m_lane[n][1], m_lane[n][0]};
      1:       return {1'b1, m_lane[n][3], m_lane[n][2]};
      2:       return {1'b1, 16'h0000, m_lane[n][4]};
`ifdef READBACK_TIMESTAMP_EN
      default: return {1'b1, m_ts[n]};
`else
      default: return {1'b1, 32'(n)};
`endif
    endcase
  endfunction

  task automatic model_update(input bit v, input logic [79:0] beat, input bit clr, input bit arm);
    if (clr) begin
      mcount = 0;
      movf   = 1'b0;
      mstate = arm ? 1 : 0;
    end else if (mstate == 0) begin
      if (arm) mstate = 1;
    end else if (mstate == 1) begin
      if (v) begin
        for (int i = 0; i < 5; i++) m_lane[mcount][i] = beat[16*i +: 16];
        m_ts[mcount] = tb_cyc;
        mcount++;
        if (mcount == int'(DEPTH)) mstate = 2;
      end
    end else if (v) begin
      movf = 1'b1;
    end
  endtask

  // One clock of stimulus; called and returns at a falling edge
  task automatic step(input bit v, input logic [79:0] beat, input bit rd, input bit wr,
                      input logic [13:0] addr, input logic [32:0] wd);
    bit is_ctrl;
    res_valid  = v;
    res_data_0 = beat[15:0];
    res_data_1 = beat[31:16];
    res_data_2 = beat[47:32];
    res_data_3 = beat[63:48];
    res_data_4 = beat[79:64];
    address    = addr;
    rd_en      = rd;
    wr_en      = wr;
    wr_data    = wd;
    if (rd) exp_q.push_back(exp_read(addr));
    is_ctrl = wr && (addr == 14'h0001);
    model_update(v, beat, is_ctrl && wd[0], is_ctrl && wd[1]);
    @(posedge clk);
    @(negedge clk);
    check1("buf_full", buf_full, mstate == 2);
    check1("capture_active", capture_active, mstate == 1);
  endtask

  task automatic idle();
    step(1'b0, 80'h0, 1'b0, 1'b0, 14'h0, 33'h0);
  endtask

  task automatic send(input logic [79:0] beat);
    step(1'b1, beat, 1'b0, 1'b0, 14'h0, 33'h0);
  endtask

  task automatic rd(input logic [13:0] a);
    step(1'b0, 80'h0, 1'b1, 1'b0, a, 33'h0);
  endtask

  task automatic wr_ctrl(input logic [32:0] v);
    step(1'b0, 80'h0, 1'b0, 1'b1, 14'h0001, v);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    res_valid = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    mstate = 0;
    mcount = 0;
    movf   = 1'b0;
    check33("rst_rd_data", rd_data, 33'h0);
    check1("rst_buf_full", buf_full, 1'b0);
    check1("rst_capture_active", capture_active, 1'b0);
  endtask

  function automatic logic [79:0] rand_beat();
    return {16'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  // Monitor: read data is due just after the edge that sampled rdEn
  always begin
    @(posedge clk);
    if (!rst && rd_en) begin
      #2;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected actual=%h required=none", rd_data);
      end else begin
        last_exp = exp_q.pop_front();
        check33("rd_data", rd_data, last_exp);
      end
    end
  end

  initial begin
    checks     = 0;
    errors     = 0;
    res_data_0 = 16'h0; res_data_1 = 16'h0; res_data_2 = 16'h0;
    res_data_3 = 16'h0; res_data_4 = 16'h0;
    address    = 14'h0;
    wr_data    = 33'h0;
    do_reset();

    // Beats in IDLE are ignored
    for (int i = 0; i < 4; i++) send(rand_beat());
    rd(14'h0000);
    check33("idle_status", rd_data, 33'h1_0000_0000);
    rd(BUF_BASE);
    check33("idle_entry0", rd_data, 33'h0);

    // Capture two beats and read entry 1 back
    wr_ctrl(33'h2);
    send({16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001});
    send({16'hEEEE, 16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA});
    rd(14'h0000);
    check33("cap_status", rd_data, 33'h1_2000_0002);
    rd(BUF_BASE + 14'd4);
    check33("e1_w0", rd_data, 33'h1_BBBB_AAAA);
    rd(BUF_BASE + 14'd5);
    check33("e1_w1", rd_data, 33'h1_DDDD_CCCC);
    rd(BUF_BASE + 14'd6);
    check33("e1_w2", rd_data, 33'h1_0000_EEEE);
    rd(BUF_BASE + 14'd7);
`ifndef READBACK_TIMESTAMP_EN
    check33("e1_w3", rd_data, 33'h1_0000_0001);
`endif
    rd(BUF_BASE);

    // Fill to DEPTH then overflow
    send({16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h0F0F});
    send({16'h9999, 16'h8888, 16'h7777, 16'h6666, 16'h5555});
    check1("full_after_4", buf_full, 1'b1);
    send(rand_beat());
    send(rand_beat());
    rd(14'h0000);
    check33("ovf_status", rd_data, 33'h1_C000_0004);
    for (int k = 0; k < 4; k++) rd(BUF_BASE + 14'd12 + 14'(k));
    rd(BUF_BASE + 14'd16);

    // CLEAR collides with a beat in CAPTURE
    wr_ctrl(33'h1);
    wr_ctrl(33'h2);
    step(1'b1, rand_beat(), 1'b0, 1'b1, 14'h0001, 33'h1);
    rd(14'h0001);
    check33("clr_status", rd_data, 33'h1_0000_0000);
    rd(BUF_BASE);

    // CLEAR+ARM with a beat: beat dropped, capture next cycle at count 0
    step(1'b1, rand_beat(), 1'b0, 1'b1, 14'h0001, 33'h3);
    send(rand_beat());
    // Read of the entry being written in the same cycle misses
    step(1'b1, rand_beat(), 1'b1, 1'b0, BUF_BASE + 14'd4, 33'h0);
    rd(BUF_BASE + 14'd4);
    rd(14'h0000);

    // Read data holds without rdEn
    for (int i = 0; i < 3; i++) begin
      send(rand_beat());
      check33("rd_hold", rd_data, last_exp);
    end
    rd(14'h0800);
    check33("unmapped", rd_data, 33'h0);

    // Reset in the middle of a capture
    wr_ctrl(33'h3);
    for (int i = 0; i < 3; i++) send(rand_beat());
    do_reset();
    wr_ctrl(33'h2);
    send({16'h00E4, 16'h00E3, 16'h00E2, 16'h00E1, 16'h00E0});
    rd(BUF_BASE);
    check33("rearm_e0_w0", rd_data, 33'h1_00E1_00E0);
    rd(BUF_BASE + 14'd1);
    rd(BUF_BASE + 14'd4);
    rd(14'h0000);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      int          r;
      bit          v;
      bit          r_en;
      bit          w_en;
      logic [13:0] a;
      logic [32:0] wd;
      r    = int'($urandom_range(0, 99));
      v    = 1'($urandom_range(0, 1));
      r_en = 1'($urandom_range(0, 1));
      w_en = 1'b0;
      wd   = 33'h0;
      case ($urandom_range(0, 4))
        0:       a = 14'($urandom_range(0, 1));
        1:       a = 14'h0800;
        2:       a = 14'($urandom);
        default: a = BUF_BASE + 14'($urandom_range(0, 4 * DEPTH + 3));
      endcase
      if (r < 10) begin
        w_en = 1'b1;
        a    = 14'h0001;
        wd   = (r < 3) ? 33'($urandom_range(1, 3)) : 33'h2;
      end else if (r < 14) begin
        w_en = 1'b1;
        wd   = 33'($urandom);
        if (a == 14'h0001) a = 14'h0002;
      end
      step(v, rand_beat(), r_en, w_en, a, wd);
    end

    idle();
    idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rd_pending actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
